// File: rtl/scarv_rom_streamer_if.sv
// rtl/scarv_rom_streamer_if.sv - command, ROM-port and stream signals of scarv_rom_streamer
interface scarv_rom_streamer_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(DEPTH) - 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW:0]      cmd_base;
    logic [AW+1:0]    cmd_len;
    logic             a_cen;
    logic [AW:0]      a_addr;
    logic [WIDTH-1:0] a_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, a_rdata, out_ready,
        output cmd_ready, a_cen, a_addr, out_valid, out_data, out_last, busy, done, checksum
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, a_rdata, out_ready,
        input  cmd_ready, a_cen, a_addr, out_valid, out_data, out_last, busy, done, checksum
    );
endinterface

// File: rtl/scarv_rom_streamer.sv
// rtl/scarv_rom_streamer.sv - ROM read streamer with 3-entry return buffer; SCARV_ROM_STREAM_CHECKSUM_EN adds XOR checksum
module scarv_rom_streamer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input logic                  g_clk,
    input logic                  g_resetn,
    scarv_rom_streamer_if.master bus
);
    localparam int AW = $clog2(DEPTH) - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW:0]      addr_q, addr_d;
    logic [AW+1:0]    rem_q, rem_d;
    logic             cen_q, cen_d;
    logic             cen_last_q, cen_last_d;
    logic             infl_q, infl_d;
    logic             infl_last_q, infl_last_d;
    logic [WIDTH-1:0] mem_q [3];
    logic [WIDTH-1:0] mem_d [3];
    logic             fl_q [3];
    logic             fl_d [3];
    logic [1:0]       rd_q, rd_d, wr_q, wr_d, cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept, push, pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;
    assign push   = infl_q;
    assign pop    = (cnt_q != 2'd0) && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cen_d       = 1'b0;
        cen_last_d  = 1'b0;
        done_d      = 1'b0;
        infl_d      = cen_q;
        infl_last_d = cen_last_q;
        mem_d       = mem_q;
        fl_d        = fl_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q + 2'(push) - 2'(pop);
        if (push) begin
            mem_d[wr_q] = bus.a_rdata;
            fl_d[wr_q]  = infl_last_q;
            wr_d        = ptr_next(wr_q);
        end
        if (pop) begin
            rd_d = ptr_next(rd_q);
        end
        // a_cen is registered, so the issue test uses next-cycle occupancy and
        // the read issued this cycle, which is next cycle's in-flight read.
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_RUN;
                        cen_d      = 1'b1;
                        addr_d     = bus.cmd_base;
                        rem_d      = bus.cmd_len - (AW+2)'(1);
                        cen_last_d = (bus.cmd_len == (AW+2)'(1));
                    end
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end else if (({1'b0, cnt_d} + {2'b00, cen_q}) < 3'd3) begin
                    cen_d      = 1'b1;
                    addr_d     = addr_q + (AW+1)'(1);
                    rem_d      = rem_q - (AW+2)'(1);
                    cen_last_d = (rem_q == (AW+2)'(1));
                end
            end
            S_DRAIN: begin
                if (cnt_d == 2'd0 && !cen_q && !infl_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            cen_q       <= 1'b0;
            cen_last_q  <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            rd_q        <= 2'd0;
            wr_q        <= 2'd0;
            cnt_q       <= 2'd0;
            done_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
                fl_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cen_q       <= cen_d;
            cen_last_q  <= cen_last_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            mem_q       <= mem_d;
            fl_q        <= fl_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.a_cen     = cen_q;
    assign bus.a_addr    = addr_q;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = mem_q[rd_q];
    assign bus.out_last  = fl_q[rd_q];
    assign bus.done      = done_q;

`ifdef SCARV_ROM_STREAM_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q ^ bus.out_data;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus.checksum = csum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign bus.checksum  = '0;
`endif
endmodule
